// File: rtl/pe_mac_seq_if.sv
`default_nettype none
// ============================================================================
// pe_mac_seq_if : start/length/bias control, buffer read and PE drive bundle
// Revision      : 1.0
// ============================================================================
interface pe_mac_seq_if #(
   parameter int LW  = 8,
   parameter int PSW = 16
);
   logic                  iStart;
   logic [LW-1:0]         iLen;
   logic signed [PSW-1:0] iBias;
   logic                  iClear;
   logic                  oRdEn;
   logic [LW-1:0]         oAddr;
   logic signed [7:0]     iWrd;
   logic signed [7:0]     iXrd;
   logic signed [7:0]     oW;
   logic signed [7:0]     oX;
   logic signed [PSW-1:0] oPsumIn;
   logic signed [PSW-1:0] iPeOut;
   logic                  oBusy;
   logic                  oDone;
   logic signed [PSW-1:0] oResult;

   modport master (
      output iStart, iLen, iBias, iClear, iWrd, iXrd, iPeOut,
      input  oRdEn, oAddr, oW, oX, oPsumIn, oBusy, oDone, oResult
   );

   modport slave (
      input  iStart, iLen, iBias, iClear, iWrd, iXrd, iPeOut,
      output oRdEn, oAddr, oW, oX, oPsumIn, oBusy, oDone, oResult
   );
endinterface
`default_nettype wire

// File: rtl/pe_mac_seq.sv
`default_nettype none
// ============================================================================
// pe_mac_seq : time-multiplexes one 8x8 signed MAC PE over a dot product
// Revision   : 1.0
// ============================================================================
module pe_mac_seq #(
   parameter int LW  = 8,
   parameter int PSW = 16
) (
   input  wire logic   iCLK,
   input  wire logic   iRSTn,
   pe_mac_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      CAPT  = 2'd3
   } state_t;

   localparam logic [LW-1:0] c_one = LW'(1);

   state_t                r_state;
   logic [LW-1:0]         r_len;
   logic [LW-1:0]         r_cnt;
   logic signed [PSW-1:0] r_bias;
   logic signed [PSW-1:0] r_result;
   logic                  r_rden;
   logic                  r_vld;
   logic                  r_first;
   logic                  r_busy;
   logic                  r_done;

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_state  <= IDLE;
         r_len    <= '0;
         r_cnt    <= '0;
         r_bias   <= '0;
         r_result <= '0;
         r_rden   <= 1'b0;
         r_vld    <= 1'b0;
         r_first  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_vld  <= r_rden;
         if (r_vld)
            r_first <= 1'b0;
         if (bus.iClear) begin
            r_state <= IDLE;
            r_rden  <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (bus.iStart) begin
                     if (bus.iLen != '0) begin
                        r_len   <= bus.iLen;
                        r_bias  <= bus.iBias;
                        r_cnt   <= '0;
                        r_rden  <= 1'b1;
                        r_first <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= FEED;
                     end else begin
                        // empty dot product: the bias is the answer
                        r_result <= bus.iBias;
                        r_done   <= 1'b1;
                     end
                  end
               end
               FEED: begin
                  if (r_cnt == r_len - c_one) begin
                     r_rden  <= 1'b0;
                     r_state <= DRAIN;
                  end else begin
                     r_cnt <= r_cnt + c_one;
                  end
               end
               DRAIN: r_state <= CAPT;
               CAPT: begin
                  r_result <= bus.iPeOut;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.oRdEn   = r_rden;
   assign bus.oAddr   = r_cnt;
   assign bus.oBusy   = r_busy;
   assign bus.oDone   = r_done;
   assign bus.oResult = r_result;

   // Zero operands outside valid cycles keep the PE's running sum unchanged.
   assign bus.oW      = r_vld ? bus.iWrd : '0;
   assign bus.oX      = r_vld ? bus.iXrd : '0;
   assign bus.oPsumIn = (r_vld && r_first) ? r_bias : bus.iPeOut;
endmodule
`default_nettype wire

// File: tb/tb_pe_mac_seq.sv
`default_nettype none
// ============================================================================
// tb_pe_mac_seq : bench with buffer/PE models and a dot-product reference
// Revision      : 1.0
// ============================================================================
module tb_pe_mac_seq;
   logic iCLK;
   logic iRSTn;
   int   n_cmp;
   int   n_err;

   logic signed [7:0] wm [256];
   logic signed [7:0] xm [256];

   pe_mac_seq_if #(.LW(8), .PSW(16)) bus ();

   pe_mac_seq #(.LW(8), .PSW(16)) dut (
      .iCLK  (iCLK),
      .iRSTn (iRSTn),
      .bus   (bus.slave)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // synchronous-read weight/activation buffers
   always @(posedge iCLK) begin
      if (bus.oRdEn) begin
         bus.iWrd <= wm[bus.oAddr];
         bus.iXrd <= xm[bus.oAddr];
      end
   end

   // PE: registered psum + w*x
   always @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)
         bus.iPeOut <= '0;
      else
         bus.iPeOut <= bus.oPsumIn + (16'(bus.oW) * 16'(bus.oX));
   end

   function automatic logic signed [15:0] ref_dot(input int len, input logic signed [15:0] bias);
      int acc;
      acc = int'(bias);
      for (int i = 0; i < len; i++)
         acc += int'(wm[i]) * int'(xm[i]);
      return acc[15:0];
   endfunction

   task automatic run_op(input int len, input logic signed [15:0] bias,
                         input int start_at, input int clr_at,
                         output int done_j, output logic signed [15:0] res,
                         output int reads, output int busy_n, output int addr_err);
      done_j = -1; reads = 0; busy_n = 0; addr_err = 0;
      bus.iStart = 1'b1;
      bus.iLen   = len[7:0];
      bus.iBias  = bias;
      @(posedge iCLK); #1;
      for (int j = 0; j < len + 10; j++) begin
         if (j > 0) begin
            @(posedge iCLK); #1;
         end
         bus.iStart = 1'b0;
         bus.iClear = 1'b0;
         if (bus.oRdEn) begin
            if (bus.oAddr !== reads[7:0] || j != reads) addr_err++;
            reads++;
         end
         if (bus.oBusy) busy_n++;
         if (bus.oDone) begin
            done_j = j;
            break;
         end
         if (j == start_at) begin
            bus.iStart = 1'b1;
            bus.iLen   = 8'd1;
         end
         if (j == clr_at) bus.iClear = 1'b1;
      end
      res = bus.oResult;
   endtask

   task automatic load_s1();
      wm[0] = 8'sd1; wm[1] = 8'sd2; wm[2] = 8'sd3; wm[3] = 8'sd4;
      xm[0] = 8'sd5; xm[1] = 8'sd6; xm[2] = 8'sd7; xm[3] = 8'sd8;
   endtask

   task automatic test_reset();
      iRSTn = 1'b0;
      bus.iStart = 1'b0; bus.iLen = '0; bus.iBias = '0; bus.iClear = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      n_cmp++; if (bus.oRdEn !== 1'b0)  begin n_err++; $display("FAIL rst_rden got %b want 0", bus.oRdEn); end
      n_cmp++; if (bus.oAddr !== 8'd0)  begin n_err++; $display("FAIL rst_addr got %0d want 0", bus.oAddr); end
      n_cmp++; if (bus.oBusy !== 1'b0)  begin n_err++; $display("FAIL rst_busy got %b want 0", bus.oBusy); end
      n_cmp++; if (bus.oDone !== 1'b0)  begin n_err++; $display("FAIL rst_done got %b want 0", bus.oDone); end
      n_cmp++; if (bus.oResult !== 16'sd0) begin n_err++; $display("FAIL rst_result got %0d want 0", bus.oResult); end
      n_cmp++; if (bus.oW !== 8'sd0 || bus.oX !== 8'sd0) begin n_err++; $display("FAIL rst_wx got %0d/%0d want 0/0", bus.oW, bus.oX); end
      n_cmp++; if (bus.oPsumIn !== 16'sd0) begin n_err++; $display("FAIL rst_psum got %0d want 0", bus.oPsumIn); end
      iRSTn = 1'b1;
      @(posedge iCLK); #1;
   endtask

   task automatic test_basic();
      int dj, rd, bn, ae;
      logic signed [15:0] res;
      load_s1();
      run_op(4, 16'sd0, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== 16'sd70) begin n_err++; $display("FAIL basic_result got %0d want 70", res); end
      n_cmp++; if (dj != 6)  begin n_err++; $display("FAIL basic_latency got %0d want 6", dj); end
      n_cmp++; if (bn != 6)  begin n_err++; $display("FAIL basic_busy got %0d want 6", bn); end
      n_cmp++; if (rd != 4 || ae != 0) begin n_err++; $display("FAIL basic_reads got %0d/%0d want 4/0", rd, ae); end
      @(posedge iCLK); #1;
      n_cmp++; if (bus.oDone !== 1'b0) begin n_err++; $display("FAIL basic_done_width got %b want 0", bus.oDone); end
      n_cmp++; if (bus.oResult !== 16'sd70) begin n_err++; $display("FAIL basic_hold got %0d want 70", bus.oResult); end
   endtask

   task automatic test_back_to_back();
      int dj, rd, bn, ae;
      logic signed [15:0] res;
      wm[0] = -8'sd128; xm[0] = -8'sd128;
      run_op(1, -16'sd100, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== 16'sd16284) begin n_err++; $display("FAIL b2b_first got %0d want 16284", res); end
      n_cmp++; if (dj != 3) begin n_err++; $display("FAIL b2b_first_lat got %0d want 3", dj); end
      wm[0] = -8'sd1; wm[1] = 8'sd2; xm[0] = 8'sd3; xm[1] = -8'sd4;
      run_op(2, 16'sd0, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== -16'sd11) begin n_err++; $display("FAIL b2b_second got %0d want -11", res); end
      n_cmp++; if (dj != 4 || rd != 2 || ae != 0) begin n_err++; $display("FAIL b2b_second_timing lat %0d reads %0d aerr %0d want 4/2/0", dj, rd, ae); end
      @(posedge iCLK); #1;
   endtask

   task automatic test_len0();
      int dj, rd, bn, ae;
      logic signed [15:0] res;
      run_op(0, 16'sd7, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== 16'sd7) begin n_err++; $display("FAIL len0_result got %0d want 7", res); end
      n_cmp++; if (dj != 0) begin n_err++; $display("FAIL len0_latency got %0d want 0", dj); end
      n_cmp++; if (rd != 0 || bn != 0) begin n_err++; $display("FAIL len0_quiet reads %0d busy %0d want 0/0", rd, bn); end
      @(posedge iCLK); #1;
   endtask

   task automatic test_overflow();
      int dj, rd, bn, ae;
      logic signed [15:0] res;
      for (int i = 0; i < 3; i++) begin wm[i] = 8'sd127; xm[i] = 8'sd127; end
      run_op(3, 16'sd0, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== -16'sd17149) begin n_err++; $display("FAIL ovf_result got %0d want -17149", res); end
      @(posedge iCLK); #1;
   endtask

   task automatic test_start_and_clear();
      int dj, rd, bn, ae;
      logic signed [15:0] res, prev;
      load_s1();
      run_op(4, 16'sd0, 2, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== 16'sd70 || dj != 6) begin n_err++; $display("FAIL ignore_start got %0d lat %0d want 70 lat 6", res, dj); end
      @(posedge iCLK); #1;
      prev = bus.oResult;
      wm[0] = 8'sd9;
      run_op(4, 16'sd5, -1, 1, dj, res, rd, bn, ae);
      n_cmp++; if (dj != -1) begin n_err++; $display("FAIL clear_nodone got %0d want -1", dj); end
      n_cmp++; if (res !== prev) begin n_err++; $display("FAIL clear_hold got %0d want %0d", res, prev); end
      n_cmp++; if (bn != 2 || rd != 2) begin n_err++; $display("FAIL clear_idle busy %0d reads %0d want 2/2", bn, rd); end
      load_s1();
      run_op(4, 16'sd0, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== 16'sd70 || dj != 6) begin n_err++; $display("FAIL clear_rerun got %0d lat %0d want 70 lat 6", res, dj); end
      @(posedge iCLK); #1;
   endtask

   task automatic test_async_reset();
      int dj, rd, bn, ae;
      logic signed [15:0] res;
      load_s1();
      bus.iStart = 1'b1; bus.iLen = 8'd4; bus.iBias = 16'sd0;
      @(posedge iCLK); #1;
      bus.iStart = 1'b0;
      repeat (4) @(posedge iCLK);
      #1;
      n_cmp++; if (bus.oBusy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy got %b want 1", bus.oBusy); end
      #2 iRSTn = 1'b0;
      #1;
      n_cmp++; if ({bus.oRdEn, bus.oBusy, bus.oDone} !== 3'b000 || bus.oResult !== 16'sd0 ||
                   bus.oW !== 8'sd0 || bus.oX !== 8'sd0 || bus.oPsumIn !== 16'sd0)
      begin
         n_err++;
         $display("FAIL arst_outputs rden %b busy %b done %b res %0d w %0d x %0d ps %0d want all 0",
                  bus.oRdEn, bus.oBusy, bus.oDone, bus.oResult, bus.oW, bus.oX, bus.oPsumIn);
      end
      @(posedge iCLK); #2 iRSTn = 1'b1;
      @(posedge iCLK); #1;
      run_op(4, 16'sd0, -1, -1, dj, res, rd, bn, ae);
      n_cmp++; if (res !== 16'sd70 || dj != 6) begin n_err++; $display("FAIL arst_rerun got %0d lat %0d want 70 lat 6", res, dj); end
      @(posedge iCLK); #1;
   endtask

   task automatic test_random();
      int dj, rd, bn, ae, len;
      logic signed [15:0] res, bias, exp;
      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < 256; i++) begin
            wm[i] = 8'($urandom);
            xm[i] = 8'($urandom);
         end
         len  = (t == 6) ? 255 : int'($urandom_range(1, 24));
         bias = 16'($urandom);
         exp  = ref_dot(len, bias);
         run_op(len, bias, -1, -1, dj, res, rd, bn, ae);
         n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rand_result len %0d got %0d want %0d", len, res, exp); end
         n_cmp++; if (dj != len + 2 || rd != len || ae != 0)
         begin
            n_err++;
            $display("FAIL rand_timing len %0d lat %0d reads %0d aerr %0d want %0d/%0d/0", len, dj, rd, ae, len + 2, len);
         end
         @(posedge iCLK); #1;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_len0();
      test_overflow();
      test_start_and_clear();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pe_mac_seq.md
Name: pe_mac_seq

Overview:
Sequencer that time-multiplexes one 8x8 signed MAC processing element (PE) to compute a dot product of programmable length. It does the following:
- Reads weight/activation pairs from two synchronous-read buffers.
- Drives the PE W/X/Psum inputs, feeding the PE's registered output back as the next partial sum.
- Captures the final sum and signals completion with a one-cycle pulse.

It sits between the layer control FSM and a single PE instance.

Parameters:
LW, 8, width of length field and buffer address
PSW, 16, partial-sum width; matches the PE's input and output psum widths

Ports:
iCLK  input  1  clock, rising edge
iRSTn  input  1  asynchronous active-low reset
iStart  input  1  start request, sampled only in IDLE
iLen  input  LW  dot-product length, 0..2^LW-1, latched on accepted start
iBias  input  PSW  signed initial psum, latched on accepted start
iClear  input  1  synchronous abort
oRdEn  output  1  buffer read enable
oAddr  output  LW  buffer read address (same address for W and X buffers)
iWrd  input  8  signed weight read data, valid the cycle after oRdEn
iXrd  input  8  signed activation read data, valid the cycle after oRdEn
oW  output  8  signed weight to PE iW
oX  output  8  signed activation to PE iX
oPsumIn  output  PSW  signed psum to PE iPsum
iPeOut  input  PSW  PE oPsum (registered in the PE)
oBusy  output  1  high in any state other than IDLE
oDone  output  1  one-cycle completion pulse
oResult  output  PSW  signed final dot product, held until the next completion

Behaviour:
- Reset (async, iRSTn=0): state=IDLE. oRdEn, oAddr, oBusy, oDone, oResult, oW, oX, oPsumIn and the internal valid pipe are all 0.
- States are IDLE, FEED, DRAIN, CAPT.
- IDLE:
  - iStart=1 and iLen!=0: latch len and bias, cnt<=0, go to FEED.
  - iStart=1 and iLen=0: oResult<=iBias and oDone<=1 at that edge; no reads are issued; stay in IDLE.
- FEED:
  - oRdEn=1 and oAddr=cnt (both registered); cnt increments each cycle.
  - After the cycle with oAddr=len-1, go to DRAIN.
  - Exactly len reads are issued, on consecutive cycles.
- Valid pipe: vld is oRdEn delayed by 1 cycle and qualifies iWrd/iXrd.
- PE drive (combinational):
  - oW = vld ? iWrd : 0; oX = vld ? iXrd : 0.
  - oPsumIn = bias on the first valid data cycle; otherwise iPeOut.
  - While vld=0, oPsumIn = iPeOut, so zero products leave the sum unchanged.
- DRAIN (1 cycle): the last operand pair is presented to the PE.
- CAPT (1 cycle):
  - iPeOut holds the full sum.
  - At the exiting edge: oResult<=iPeOut, oDone<=1, go to IDLE.
- Latency:
  - Start sampled at edge E0 → oDone high in the cycle after edge E0+len+2.
  - Throughput is one MAC per cycle.
- oDone is high for exactly one cycle.
- A start presented during the oDone cycle is accepted, since the state is IDLE.
- iStart while oBusy=1 is ignored, with no queuing.
- Arithmetic:
  - Product is a 16-bit signed value; accumulation is PSW-bit two's complement and wraps with no saturation, matching the PE.
  - −128×−128 = 16384 must be exact.
- iClear=1 (any state):
  - Next state is IDLE; oRdEn<=0 and the valid pipe is cleared.
  - No oDone; oResult keeps its previous value.
  - iClear has priority over iStart in the same cycle.
- Async reset mid-operation: immediate return to reset values; the next start behaves normally.
- len=2^LW-1 (max): addresses 0..2^LW-2 are read; cnt must not wrap before the FEED exit.

Test Plan:
1. len=4, W={1,2,3,4}, X={5,6,7,8}, bias=0 → oAddr 0..3 on consecutive cycles, oResult=70, oDone exactly 6 cycles after the start edge, oBusy high for 6 cycles.
2. len=1, W=−128, X=−128, bias=−100 → oResult=16284; then back-to-back start (iStart in the oDone cycle) with len=2, W={−1,2}, X={3,−4}, bias=0 → oResult=−11.
3. len=0, bias=7 → oDone on the cycle after the start edge, oResult=7, oRdEn never asserted, oBusy stays 0.
4. Overflow: len=3, all W=X=127, bias=0 → 48387 wraps to oResult=−17149 (PSW=16).
5. iStart pulsed mid-FEED is ignored, and the result is unchanged from scenario 1. iClear at the 2nd FEED cycle → IDLE next cycle, no oDone, oResult retains its previous value, and a subsequent run returns the correct value.
6. iRSTn low during DRAIN → all outputs 0 asynchronously; after release, a scenario-1 run gives 70 with nominal latency.
